data_mem_resp: RTL

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/bmm_pkg.sv | 21 ++
 rtl/dmem_sram_be.sv | 30 +++
 rtl/data_mem_resp.sv | 112 +++++++++++
 3 files changed

// File: rtl/bmm_pkg.sv
// Shared constants and response type for the data memory responder.
package bmm_pkg;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1000_0000;
  localparam int          DMEM_WORDS     = 1024;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } dmem_rsp_t;

  // Expands a 4-bit byte enable into a 32-bit bit mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_sram_be.sv
// Word-addressed storage with per-byte write enables and a combinational read port.
module dmem_sram_be
  import bmm_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] mask;

  assign mask = be_to_mask(be);

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_resp.sv
// LSU-facing data memory: combinational grant, credit counter and fixed-latency response pipe.
module data_mem_resp
  import bmm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = DMEM_BASE_ADDR,
  parameter int          MEM_WORDS       = DMEM_WORDS,
  parameter int          RESP_LATENCY    = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic        stall_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int              AW      = $clog2(MEM_WORDS);
  localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [32:0]     SPAN    = 33'(MEM_WORDS) << 2;

  logic [31:0]   offset;
  logic          in_range;
  logic          accept;
  logic          rsp_vld;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [31:0]   sram_rdata;
  dmem_rsp_t     rsp_in;
  dmem_rsp_t     rsp_out;

  logic          vld_p [RESP_LATENCY];
  dmem_rsp_t     rsp_p [RESP_LATENCY];

  // Offset comparison avoids overflow when BASE_ADDR sits near the top of the map.
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = (data_addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);

  // A response retiring this cycle does not free a credit until the next cycle.
  assign data_gnt_o = rst_ni && data_req_i && !stall_i && (cnt < MAX_CNT);
  assign accept     = data_req_i && data_gnt_o;

  dmem_sram_be #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk   (clk_i),
    .addr  (offset[AW+1:2]),
    .we    (accept && data_we_i && in_range),
    .be    (data_be_i),
    .wdata (data_wdata_i),
    .rdata (sram_rdata)
  );

  always_comb begin
    rsp_in.err   = !in_range;
    rsp_in.rdata = (in_range && !data_we_i) ? sram_rdata : 32'h0;
  end

  // Stage 0 captures at the accept edge; the last stage drives the outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RESP_LATENCY; i++) begin
        vld_p[i] <= 1'b0;
      end
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    rsp_p[0] <= rsp_in;
    for (int i = 1; i < RESP_LATENCY; i++) begin
      rsp_p[i] <= rsp_p[i-1];
    end
  end

  assign rsp_vld = vld_p[RESP_LATENCY-1];
  assign rsp_out = rsp_p[RESP_LATENCY-1];

  always_comb begin
    cnt_nxt = cnt;
    if (accept && !rsp_vld) begin
      cnt_nxt = cnt + 1'b1;
    end else if (!accept && rsp_vld) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign data_rvalid_o = rsp_vld;
  assign data_rdata_o  = rsp_vld ? rsp_out.rdata : 32'h0;
  assign data_err_o    = rsp_vld && rsp_out.err;

endmodule
